// File: rtl/isect_pkg.sv
// Shared light codes, checker error codes and departure FSM encoding for the
// intersection model.
package isect_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CONFLICT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_SEQUENCE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } depart_state_e;

  // Forbidden light steps: GREEN->RED, RED->YELLOW, YELLOW->GREEN.
  function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic r;
    r = ((prev == LIGHT_GREEN)  && (cur == LIGHT_RED))    ||
        ((prev == LIGHT_RED)    && (cur == LIGHT_YELLOW)) ||
        ((prev == LIGHT_YELLOW) && (cur == LIGHT_GREEN));
    return r;
  endfunction

endpackage

// File: rtl/street_queue.sv
// One street of the intersection: saturating car queue, sticky overflow flag
// and a departure FSM that releases one car per DEPART_CYC cycles of green.
module street_queue
  import isect_pkg::*;
#(
  parameter int Q_W        = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_arr,
  input  logic [1:0]     i_light,
  output logic [Q_W-1:0] o_q,
  output logic           o_ovf,
  output logic           o_present
);

  localparam logic [Q_W-1:0] Q_MAX  = {Q_W{1'b1}};
  localparam logic [Q_W-1:0] Q_ZERO = {Q_W{1'b0}};
  localparam logic [Q_W-1:0] Q_ONE  = Q_W'(1);
  localparam logic [3:0]     T_LAST = 4'(DEPART_CYC - 1);

  depart_state_e  r_state;
  depart_state_e  w_state_nxt;
  logic [3:0]     r_timer;
  logic [3:0]     w_timer_nxt;
  logic [Q_W-1:0] r_q;
  logic [Q_W-1:0] w_q_nxt;
  logic           r_ovf;
  logic           w_ovf_nxt;
  logic           r_present;
  logic           w_dep;
  logic           w_green;
  logic           w_has_car;
  logic           w_at_last;

  // Only GREEN drains; YELLOW, RED and the illegal code all hold the queue.
  assign w_green   = (i_light == LIGHT_GREEN);
  assign w_has_car = (r_q != Q_ZERO);
  assign w_at_last = (r_timer == T_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dep       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_green && w_has_car) begin
          w_state_nxt = ST_DRAIN;
          w_dep       = w_at_last;
          w_timer_nxt = w_at_last ? 4'd0 : r_timer + 4'd1;
        end else begin
          w_timer_nxt = 4'd0;
        end
      end
      ST_DRAIN: begin
        if (!w_green || !w_has_car) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = 4'd0;
        end else begin
          w_dep       = w_at_last;
          w_timer_nxt = w_at_last ? 4'd0 : r_timer + 4'd1;
          if (w_at_last && (r_q == Q_ONE) && !i_arr) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 4'd0;
      end
    endcase
  end

  // An arrival and a departure on the same edge cancel out.
  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = r_ovf;
    if (i_arr && !w_dep) begin
      if (r_q == Q_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_q_nxt = r_q + Q_ONE;
      end
    end else if (w_dep && !i_arr) begin
      w_q_nxt = r_q - Q_ONE;
    end else begin
      w_q_nxt = r_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= 4'd0;
      r_q       <= Q_ZERO;
      r_ovf     <= 1'b0;
      r_present <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_q       <= w_q_nxt;
      r_ovf     <= w_ovf_nxt;
      r_present <= (w_q_nxt != Q_ZERO);
    end
  end

  assign o_q       = r_q;
  assign o_ovf     = r_ovf;
  assign o_present = r_present;

endmodule

// File: rtl/traffic_intersection_model.sv
// Closed-loop intersection model producing TA/TB sensor inputs from light codes
// and car arrivals. Define ISECT_SAFETY_CHECK_EN to build the light-sequence checker.
module traffic_intersection_model
  import isect_pkg::*;
#(
  parameter int Q_W        = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic           isect_clk,
  input  logic           isect_rstn,
  input  logic           arr_A,
  input  logic           arr_B,
  input  logic [1:0]     LA,
  input  logic [1:0]     LB,
  output logic           TA,
  output logic           TB,
  output logic [Q_W-1:0] qA,
  output logic [Q_W-1:0] qB,
  output logic           ovf_A,
  output logic           ovf_B,
  output logic           err,
  output logic [1:0]     err_code
);

  street_queue #(.Q_W(Q_W), .DEPART_CYC(DEPART_CYC)) u_street_a (
    .i_clk     (isect_clk),
    .i_rst_n   (isect_rstn),
    .i_arr     (arr_A),
    .i_light   (LA),
    .o_q       (qA),
    .o_ovf     (ovf_A),
    .o_present (TA)
  );

  street_queue #(.Q_W(Q_W), .DEPART_CYC(DEPART_CYC)) u_street_b (
    .i_clk     (isect_clk),
    .i_rst_n   (isect_rstn),
    .i_arr     (arr_B),
    .i_light   (LB),
    .o_q       (qB),
    .o_ovf     (ovf_B),
    .o_present (TB)
  );

`ifdef ISECT_SAFETY_CHECK_EN
  logic [1:0] r_prev_la;
  logic [1:0] r_prev_lb;
  logic       r_err;
  logic [1:0] r_err_code;
  logic [1:0] w_viol;

  // Highest-priority violation seen this cycle; ERR_NONE if the lights are sane.
  always_comb begin
    w_viol = ERR_NONE;
    if ((LA != LIGHT_RED) && (LB != LIGHT_RED)) begin
      w_viol = ERR_CONFLICT;
    end else if ((LA == 2'b10) || (LB == 2'b10)) begin
      w_viol = ERR_ILLEGAL;
    end else if (bad_step(r_prev_la, LA) || bad_step(r_prev_lb, LB)) begin
      w_viol = ERR_SEQUENCE;
    end else begin
      w_viol = ERR_NONE;
    end
  end

  always_ff @(posedge isect_clk or negedge isect_rstn) begin
    if (!isect_rstn) begin
      r_prev_la  <= LIGHT_RED;
      r_prev_lb  <= LIGHT_RED;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_prev_la <= LA;
      r_prev_lb <= LB;
      if (!r_err && (w_viol != ERR_NONE)) begin
        r_err      <= 1'b1;
        r_err_code <= w_viol;
      end
    end
  end

  assign err      = r_err;
  assign err_code = r_err_code;
`else
  assign err      = 1'b0;
  assign err_code = 2'b00;
`endif

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Directed bench for traffic_intersection_model: two instances (DEPART_CYC 2 and 1)
// share stimulus and are compared every cycle against a queue-level model.
module tb_traffic_intersection_model;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b11;
  localparam logic [1:0] BADC   = 2'b10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       arr_A = 1'b0;
  logic       arr_B = 1'b0;
  logic [1:0] LA = GREEN;
  logic [1:0] LB = RED;

  logic       ta [2];
  logic       tb [2];
  logic [3:0] qa [2];
  logic [3:0] qb [2];
  logic       ova [2];
  logic       ovb [2];
  logic       er [2];
  logic [1:0] ec [2];

  int n_pass = 0;
  int n_tot  = 0;

  // Model state: queue length, green cycles served toward the next car, overflow.
  int  mq [2][2];
  int  mp [2][2];
  bit  mo [2][2];
  int  dcs [2] = '{2, 1};
  bit  merr;
  int  mcode;
  logic [1:0] mprev [2];

  always #5 clk = ~clk;

  traffic_intersection_model #(.Q_W(4), .DEPART_CYC(2)) dut0 (
    .isect_clk(clk), .isect_rstn(rstn), .arr_A(arr_A), .arr_B(arr_B),
    .LA(LA), .LB(LB), .TA(ta[0]), .TB(tb[0]), .qA(qa[0]), .qB(qb[0]),
    .ovf_A(ova[0]), .ovf_B(ovb[0]), .err(er[0]), .err_code(ec[0])
  );

  traffic_intersection_model #(.Q_W(4), .DEPART_CYC(1)) dut1 (
    .isect_clk(clk), .isect_rstn(rstn), .arr_A(arr_A), .arr_B(arr_B),
    .LA(LA), .LB(LB), .TA(ta[1]), .TB(tb[1]), .qA(qa[1]), .qB(qb[1]),
    .ovf_A(ova[1]), .ovf_B(ovb[1]), .err(er[1]), .err_code(ec[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit bad_seq(input logic [1:0] p, input logic [1:0] c);
    return (p == GREEN && c == RED) || (p == RED && c == YELLOW) || (p == YELLOW && c == GREEN);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++) begin
        mq[d][s] = 0; mp[d][s] = 0; mo[d][s] = 1'b0;
      end
    merr = 1'b0; mcode = 0; mprev[0] = RED; mprev[1] = RED;
  endtask

  task automatic model_step();
    logic [1:0] lt [2];
    bit ar [2];
    bit dep;
    int v;
    if (!rstn) begin
      model_reset();
    end else begin
      lt[0] = LA; lt[1] = LB; ar[0] = arr_A; ar[1] = arr_B;
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 2; s++) begin
          dep = 1'b0;
          if (lt[s] == GREEN && mq[d][s] > 0) begin
            mp[d][s]++;
            if (mp[d][s] == dcs[d]) begin dep = 1'b1; mp[d][s] = 0; end
          end else begin
            mp[d][s] = 0;
          end
          if (ar[s] && !dep) begin
            if (mq[d][s] == 15) mo[d][s] = 1'b1;
            else mq[d][s]++;
          end else if (dep && !ar[s]) begin
            mq[d][s]--;
          end
        end
`ifdef ISECT_SAFETY_CHECK_EN
      if (LA != RED && LB != RED) v = 1;
      else if (LA == BADC || LB == BADC) v = 2;
      else if (bad_seq(mprev[0], LA) || bad_seq(mprev[1], LB)) v = 3;
      else v = 0;
      if (!merr && v != 0) begin merr = 1'b1; mcode = v; end
`else
      v = 0;
`endif
      mprev[0] = LA; mprev[1] = LB;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d qA", d), qa[d], mq[d][0]);
      chk($sformatf("d%0d qB", d), qb[d], mq[d][1]);
      chk($sformatf("d%0d TA", d), ta[d], int'(mq[d][0] != 0));
      chk($sformatf("d%0d TB", d), tb[d], int'(mq[d][1] != 0));
      chk($sformatf("d%0d ovf_A", d), ova[d], mo[d][0]);
      chk($sformatf("d%0d ovf_B", d), ovb[d], mo[d][1]);
      chk($sformatf("d%0d err", d), er[d], merr);
      chk($sformatf("d%0d err_code", d), ec[d], mcode);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) compare_all();

  initial begin
    model_reset();
    #12 rstn = 1'b1;
    chk("reset qA", qa[0], 0);
    chk("reset TA", ta[0], 0);
    chk("reset ovf_A", ova[0], 0);
    chk("reset err", er[0], 0);

    // Single arrival on green: visible after one edge, gone two edges later.
    tick();
    arr_A = 1'b1; tick(); arr_A = 1'b0;
    chk("t1 TA after arrival", ta[0], 1);
    chk("t1 qA after arrival", qa[0], 1);
    tick();
    chk("t1 qA mid service", qa[0], 1);
    tick();
    chk("t1 qA departed", qa[0], 0);
    chk("t1 TA cleared", ta[0], 0);

    // Saturation and sticky overflow.
    LA = YELLOW; tick(); LA = RED; tick();
    arr_A = 1'b1;
    repeat (15) tick();
    chk("t2 qA full", qa[0], 15);
    chk("t2 ovf before drop", ova[0], 0);
    tick();
    chk("t2 qA held", qa[0], 15);
    chk("t2 ovf set", ova[0], 1);
    arr_A = 1'b0; LA = GREEN;
    repeat (34) tick();
    chk("t2 qA drained", qa[0], 0);
    chk("t2 ovf sticky", ova[0], 1);
    LA = YELLOW; tick(); LA = RED; tick();

    // Continuous arrivals while draining at one car per cycle.
    arr_B = 1'b1;
    repeat (3) tick();
    chk("t3 qB preload", qb[0], 3);
    LB = GREEN;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3 qB steady dc1", qb[1], 3);
    end
    chk("t3 qB growing dc2", qb[0], 6);
    arr_B = 1'b0;
    repeat (14) tick();
    chk("t3 qB drained", qb[0], 0);
    LB = YELLOW; tick(); LB = RED; tick();

    // One green cycle then yellow: no departure and partial progress lost.
    arr_A = 1'b1;
    repeat (4) tick();
    arr_A = 1'b0;
    chk("t4 qA preload", qa[0], 4);
    LA = GREEN; tick();
    chk("t4 qA after 1 green", qa[0], 4);
    LA = YELLOW; repeat (2) tick();
    chk("t4 qA yellow hold", qa[0], 4);
    LA = RED; tick();
    LA = GREEN; tick();
    chk("t4 timer was cleared", qa[0], 4);
    tick();
    chk("t4 qA one departure", qa[0], 3);

    // Asynchronous reset in the middle of a drain.
    LA = YELLOW; tick(); LA = RED; tick();
    arr_A = 1'b1; repeat (2) tick(); arr_A = 1'b0;
    chk("t6 qA preload", qa[0], 5);
    LA = GREEN; tick();
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("t6 async qA", qa[0], 0);
    chk("t6 async TA", ta[0], 0);
    chk("t6 async ovf_A", ova[0], 0);
    compare_all();
    arr_A = 1'b1; LA = RED; LB = RED;
    repeat (2) tick();
    chk("t6 arrivals ignored", qa[0], 0);
    arr_A = 1'b0;
    #2 rstn = 1'b1;

    // Safety checker: conflict first, later illegal code ignored, then bad step.
    LA = GREEN; LB = YELLOW; tick();
`ifdef ISECT_SAFETY_CHECK_EN
    chk("t5 conflict err", er[0], 1);
    chk("t5 conflict code", ec[0], 1);
`else
    chk("t5 err tied low", er[0], 0);
    chk("t5 code tied low", ec[0], 0);
`endif
    LA = BADC; LB = RED; tick();
`ifdef ISECT_SAFETY_CHECK_EN
    chk("t5 code kept", ec[0], 1);
`else
    chk("t5 code still low", ec[0], 0);
`endif
    #2 rstn = 1'b0;
    model_reset();
    LA = RED; LB = RED;
    tick();
    #2 rstn = 1'b1;
    LA = GREEN; tick();
    LA = RED; tick();
`ifdef ISECT_SAFETY_CHECK_EN
    chk("t5 sequence err", er[0], 1);
    chk("t5 sequence code", ec[0], 3);
`else
    chk("t5 sequence err low", er[0], 0);
`endif
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
